vblank_write_arbiter: RTL and testbench

- Shares the single write port of the game-grid memory among NREQ requesters: 0 = snake mover, 1 = food placer, 2 = score/border painter.
- Writes are allowed only during the vertical-blanking window. The window is derived from the ycount produced by the VGA sync block, so the pixel renderer never reads a half-updated frame.
- Issues a one-cycle frame_tick that starts the game logic for each frame.
- Enforces a per-frame write budget and flags requesters left unserved when the window closes.

---
 rtl/vblank_write_arbiter.sv | 172 +++++++++++++++++
 tb/tb_vblank_write_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vblank_write_arbiter.sv
// Write-port arbiter for the game-grid memory. Grants writes only while the
// vertical-blanking window is open, round-robins between requesters, caps the
// number of writes per frame and flags requesters left waiting at window close.
module vblank_write_arbiter #(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 2,
    parameter int unsigned WIN_START = 480,
    parameter int unsigned WIN_END   = 524,
    parameter int unsigned MAX_WR    = 256
) (
    input  logic                     vga_clk,
    input  logic                     reset,
    input  logic [9:0]               ycount,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic                     clear_missed,
    output logic [NREQ-1:0]          gnt,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     frame_tick,
    output logic                     window_open,
    output logic                     budget_full,
    output logic [NREQ-1:0]          missed
);

    localparam int unsigned CntW = $clog2(MAX_WR + 1);
    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CntW-1:0] MaxCnt   = CntW'(MAX_WR);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(NREQ - 1);
    localparam logic [9:0]      WinStart = 10'(WIN_START);
    localparam logic [9:0]      WinEnd   = 10'(WIN_END);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOpen = 2'd1;
    localparam logic [1:0] StFull = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              win_q, win_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              frame_tick_q, frame_tick_d;
    logic [NREQ-1:0]   missed_q, missed_d;

    logic [ADDR_W-1:0] addr_arr [NREQ];
    logic [DATA_W-1:0] data_arr [NREQ];
    logic [NREQ-1:0]   eligible;
    logic              found;
    logic [PtrW-1:0]   winner;
    logic [PtrW-1:0]   idx;

    // Window decode; the FSM only ever looks at the registered copy
    always_comb begin
        win_d = (ycount >= WinStart) && (ycount < WinEnd);
    end

    // Split the flat request buses into per-requester fields
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin pick; last cycle's grantee is masked since it still holds req
    always_comb begin
        eligible = req & ~gnt_q;
        found    = 1'b0;
        winner   = '0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PtrW'((int'(rr_ptr_q) + k) % NREQ);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Next-state: window FSM, grant issue, budget and missed-flag bookkeeping
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = '0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        frame_tick_d = 1'b0;
        // Clear first so a same-cycle set below takes priority
        missed_d     = clear_missed ? '0 : missed_q;

        case (state_q)
            StIdle: begin
                if (win_q) begin
                    state_d      = StOpen;
                    frame_tick_d = 1'b1;
                    count_d      = '0;
                end
            end
            StOpen: begin
                if (!win_q) begin
                    state_d  = StIdle;
                    missed_d = missed_d | req;
                end else if ((count_q < MaxCnt) && found) begin
                    gnt_d[winner] = 1'b1;
                    mem_we_d      = 1'b1;
                    mem_addr_d    = addr_arr[winner];
                    mem_wdata_d   = data_arr[winner];
                    count_d       = count_q + 1'b1;
                    rr_ptr_d      = (winner == LastPtr) ? '0 : winner + 1'b1;
                    if ((count_q + 1'b1) == MaxCnt) begin
                        state_d = StFull;
                    end
                end
            end
            StFull: begin
                if (!win_q) begin
                    state_d  = StIdle;
                    missed_d = missed_d | req;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            win_q        <= 1'b0;
            count_q      <= '0;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            frame_tick_q <= 1'b0;
            missed_q     <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            count_q      <= count_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            frame_tick_q <= frame_tick_d;
            missed_q     <= missed_d;
        end
    end

    assign gnt         = gnt_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign frame_tick  = frame_tick_q;
    assign window_open = (state_q != StIdle);
    assign budget_full = (state_q == StFull);
    assign missed      = missed_q;

endmodule

// File: tb/tb_vblank_write_arbiter.sv
// Bench for vblank_write_arbiter: a default instance (budget 256) and a small
// budget instance (4) share stimulus and are both compared to a reference model.
module tb_vblank_write_arbiter;

    logic        clk;
    logic        reset;
    logic [9:0]  ycount;
    logic [2:0]  req;
    logic [32:0] req_addr;
    logic [5:0]  req_data;
    logic        clear_missed;

    logic [2:0]  gnt_a, gnt_b, missed_a, missed_b;
    logic        we_a, we_b, tick_a, tick_b, open_a, open_b, full_a, full_b;
    logic [10:0] addr_a, addr_b;
    logic [1:0]  wdata_a, wdata_b;

    logic [10:0] a_tbl [3];
    logic [1:0]  d_tbl [3];

    int n_checks = 0;
    int n_pass   = 0;

    vblank_write_arbiter dut_a (
        .vga_clk(clk), .reset(reset), .ycount(ycount), .req(req), .req_addr(req_addr),
        .req_data(req_data), .clear_missed(clear_missed), .gnt(gnt_a), .mem_we(we_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .frame_tick(tick_a), .window_open(open_a),
        .budget_full(full_a), .missed(missed_a)
    );

    vblank_write_arbiter #(.MAX_WR(4)) dut_b (
        .vga_clk(clk), .reset(reset), .ycount(ycount), .req(req), .req_addr(req_addr),
        .req_data(req_data), .clear_missed(clear_missed), .gnt(gnt_b), .mem_we(we_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .frame_tick(tick_b), .window_open(open_b),
        .budget_full(full_b), .missed(missed_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one slot per instance
    int          m_max [2];
    logic        m_win [2];
    logic        m_active [2];
    logic        m_exh [2];
    int          m_used [2];
    int          m_rr [2];
    logic [2:0]  m_gnt [2];
    logic        m_we [2];
    logic [10:0] m_addr [2];
    logic [1:0]  m_data [2];
    logic        m_tick [2];
    logic [2:0]  m_missed [2];

    task automatic model_reset(input bit kk);
        m_win[kk] = 0; m_active[kk] = 0; m_exh[kk] = 0; m_used[kk] = 0; m_rr[kk] = 0;
        m_gnt[kk] = 0; m_we[kk] = 0; m_addr[kk] = 0; m_data[kk] = 0; m_tick[kk] = 0;
        m_missed[kk] = 0;
    endtask

    task automatic model_step(input bit kk);
        logic       was_win;
        logic [2:0] last_gnt;
        logic [1:0] id;
        int         pick;
        if (reset) begin
            model_reset(kk);
        end else begin
            was_win   = m_win[kk];
            last_gnt  = m_gnt[kk];
            pick      = -1;
            m_win[kk] = (ycount >= 10'd480) && (ycount < 10'd524);
            m_gnt[kk] = 0; m_we[kk] = 0; m_tick[kk] = 0;
            if (clear_missed) m_missed[kk] = 0;
            if (!m_active[kk]) begin
                if (was_win) begin
                    m_active[kk] = 1; m_tick[kk] = 1; m_used[kk] = 0;
                end
            end else if (!was_win) begin
                m_active[kk] = 0; m_exh[kk] = 0;
                m_missed[kk] = m_missed[kk] | req;
            end else if (!m_exh[kk]) begin
                for (int j = 0; j < 3; j++) begin
                    id = 2'((m_rr[kk] + j) % 3);
                    if (pick < 0 && req[id] && !last_gnt[id]) pick = int'(id);
                end
                if (pick >= 0) begin
                    m_gnt[kk]  = 3'(1 << pick);
                    m_we[kk]   = 1;
                    m_addr[kk] = a_tbl[2'(pick)];
                    m_data[kk] = d_tbl[2'(pick)];
                    m_used[kk] = m_used[kk] + 1;
                    m_rr[kk]   = (pick + 1) % 3;
                    if (m_used[kk] == m_max[kk]) m_exh[kk] = 1;
                end
            end
        end
    endtask

    function automatic logic [22:0] pack_m(input bit kk);
        return {m_gnt[kk], m_we[kk], m_addr[kk], m_data[kk], m_tick[kk], m_active[kk],
                m_exh[kk], m_missed[kk]};
    endfunction

    function automatic logic [22:0] pack_a();
        return {gnt_a, we_a, addr_a, wdata_a, tick_a, open_a, full_a, missed_a};
    endfunction

    function automatic logic [22:0] pack_b();
        return {gnt_b, we_b, addr_b, wdata_b, tick_b, open_b, full_b, missed_b};
    endfunction

    task automatic drive_bus();
        req_addr = {a_tbl[2], a_tbl[1], a_tbl[0]};
        req_data = {d_tbl[2], d_tbl[1], d_tbl[0]};
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(1'b0);
        model_step(1'b1);
        @(negedge clk);
    endtask

    task automatic open_window();
        ycount = 10'd490; cycle(); cycle();
    endtask

    task automatic close_window();
        ycount = 10'd0; cycle(); cycle();
    endtask

    task automatic test_reset();
        n_checks++; if (pack_a() !== 23'd0) $display("FAIL reset_a: got %h expected 0", pack_a()); else n_pass++;
        n_checks++; if (pack_b() !== 23'd0) $display("FAIL reset_b: got %h expected 0", pack_b()); else n_pass++;
        cycle(); cycle();
        reset = 0; ycount = 10'd490;
        cycle();
        n_checks++; if ({tick_a, open_a} !== 2'b00) $display("FAIL lag_cycle: got %b expected 00", {tick_a, open_a}); else n_pass++;
        cycle();
        n_checks++; if ({tick_a, open_a} !== 2'b11) $display("FAIL entry_tick: got %b expected 11", {tick_a, open_a}); else n_pass++;
        cycle();
        n_checks++; if ({tick_a, open_a} !== 2'b01) $display("FAIL tick_once: got %b expected 01", {tick_a, open_a}); else n_pass++;
        reset = 1;
        #1;
        n_checks++; if (pack_a() !== 23'd0) $display("FAIL async_reset: got %h expected 0", pack_a()); else n_pass++;
        cycle();
    endtask

    task automatic test_sweep();
        int ticks = 0;
        int opens = 0;
        ycount = 10'd0; reset = 0;
        for (int v = 0; v < 528; v++) begin
            ycount = (v < 525) ? 10'(v) : 10'd0;
            cycle();
            n_checks++; if (pack_a() !== pack_m(1'b0)) $display("FAIL sweep_a: got %h expected %h", pack_a(), pack_m(1'b0)); else n_pass++;
            if (tick_a) ticks++;
            if (open_a) opens++;
        end
        n_checks++; if (ticks != 1) $display("FAIL sweep_ticks: got %0d expected 1", ticks); else n_pass++;
        n_checks++; if (opens != 44) $display("FAIL sweep_open: got %0d expected 44", opens); else n_pass++;
    endtask

    task automatic test_rotation();
        logic [2:0] exp_g;
        a_tbl[0] = 11'h0F0; a_tbl[1] = 11'h155; a_tbl[2] = 11'h2AA;
        d_tbl[0] = 2'd1; d_tbl[1] = 2'd2; d_tbl[2] = 2'd3;
        drive_bus();
        open_window();
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            cycle();
            exp_g = 3'(1 << (i % 3));
            n_checks++; if ({gnt_a, we_a} !== {exp_g, 1'b1}) $display("FAIL rot_gnt: got %b expected %b", {gnt_a, we_a}, {exp_g, 1'b1}); else n_pass++;
            n_checks++; if (addr_a !== a_tbl[2'(i % 3)]) $display("FAIL rot_addr: got %h expected %h", addr_a, a_tbl[2'(i % 3)]); else n_pass++;
            n_checks++; if (pack_b() !== pack_m(1'b1)) $display("FAIL rot_b: got %h expected %h", pack_b(), pack_m(1'b1)); else n_pass++;
        end
        req = 3'b000;
        cycle();
        n_checks++; if ({gnt_a, we_a} !== 4'b0000) $display("FAIL rot_idle: got %b expected 0000", {gnt_a, we_a}); else n_pass++;
        close_window();
    endtask

    task automatic test_single();
        open_window();
        a_tbl[1] = 11'h123; d_tbl[1] = 2'd2; drive_bus();
        req = 3'b010;
        cycle();
        n_checks++; if ({gnt_a, we_a, addr_a, wdata_a} !== {3'b010, 1'b1, 11'h123, 2'd2}) $display("FAIL single_grant: got %h expected %h", {gnt_a, we_a, addr_a, wdata_a}, {3'b010, 1'b1, 11'h123, 2'd2}); else n_pass++;
        cycle();
        n_checks++; if ({gnt_a, we_a, addr_a} !== {3'b000, 1'b0, 11'h123}) $display("FAIL single_gap: got %h expected %h", {gnt_a, we_a, addr_a}, {3'b000, 1'b0, 11'h123}); else n_pass++;
        cycle();
        n_checks++; if ({gnt_a, we_a} !== 4'b0101) $display("FAIL single_regrant: got %b expected 0101", {gnt_a, we_a}); else n_pass++;
        req = 3'b000;
        cycle();
        close_window();
    endtask

    task automatic test_budget();
        int nga = 0;
        int ngb = 0;
        open_window();
        a_tbl[0] = 11'h05A; d_tbl[0] = 2'd3; drive_bus();
        req = 3'b001;
        for (int i = 0; i < 12; i++) begin
            cycle();
            n_checks++; if (pack_b() !== pack_m(1'b1)) $display("FAIL budget_b: got %h expected %h", pack_b(), pack_m(1'b1)); else n_pass++;
            if (gnt_a[0]) nga++;
            if (gnt_b[0]) ngb++;
        end
        n_checks++; if (ngb != 4) $display("FAIL budget_count_b: got %0d expected 4", ngb); else n_pass++;
        n_checks++; if (nga != 6) $display("FAIL budget_count_a: got %0d expected 6", nga); else n_pass++;
        n_checks++; if ({full_a, full_b} !== 2'b01) $display("FAIL budget_full: got %b expected 01", {full_a, full_b}); else n_pass++;
        close_window();
        n_checks++; if ({missed_a, missed_b, open_b, full_b} !== 8'b001_001_00) $display("FAIL budget_missed: got %b expected 00100100", {missed_a, missed_b, open_b, full_b}); else n_pass++;
        req = 3'b000; clear_missed = 1;
        cycle();
        clear_missed = 0;
        n_checks++; if ({missed_a, missed_b} !== 6'b0) $display("FAIL missed_clear: got %b expected 000000", {missed_a, missed_b}); else n_pass++;
    endtask

    task automatic test_display_req();
        ycount = 10'd200;
        a_tbl[2] = 11'h3C5; d_tbl[2] = 2'd1; drive_bus();
        req = 3'b100;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_checks++; if ({gnt_a, we_a} !== 4'b0) $display("FAIL display_nogrant: got %b expected 0000", {gnt_a, we_a}); else n_pass++;
        end
        ycount = 10'd480;
        cycle();
        n_checks++; if ({gnt_a, tick_a} !== 4'b0) $display("FAIL display_lag: got %b expected 0000", {gnt_a, tick_a}); else n_pass++;
        cycle();
        n_checks++; if ({gnt_a, tick_a} !== 4'b0001) $display("FAIL display_entry: got %b expected 0001", {gnt_a, tick_a}); else n_pass++;
        cycle();
        n_checks++; if ({gnt_a, addr_a, wdata_a} !== {3'b100, 11'h3C5, 2'd1}) $display("FAIL display_first_arb: got %h expected %h", {gnt_a, addr_a, wdata_a}, {3'b100, 11'h3C5, 2'd1}); else n_pass++;
        req = 3'b000;
        cycle();
        close_window();
    endtask

    task automatic test_missed_clear();
        open_window();
        req = 3'b010;
        cycle(); cycle(); cycle();
        ycount = 10'd0;
        cycle();
        clear_missed = 1;
        cycle();
        clear_missed = 0;
        n_checks++; if ({missed_a, missed_b, open_a} !== 7'b010_010_0) $display("FAIL set_beats_clear: got %b expected 0100100", {missed_a, missed_b, open_a}); else n_pass++;
        req = 3'b000; clear_missed = 1;
        cycle();
        clear_missed = 0;
        n_checks++; if (missed_a !== 3'b000) $display("FAIL clear_after: got %b expected 000", missed_a); else n_pass++;
    endtask

    task automatic test_random();
        int v = 470;
        for (int n = 0; n < 600; n++) begin
            ycount = 10'(v);
            v = (v == 524) ? 0 : ((v == 0) ? 470 : v + 1);
            clear_missed = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 249) == 0);
            cycle();
            n_checks++; if (pack_a() !== pack_m(1'b0)) $display("FAIL random_a: got %h expected %h", pack_a(), pack_m(1'b0)); else n_pass++;
            n_checks++; if (pack_b() !== pack_m(1'b1)) $display("FAIL random_b: got %h expected %h", pack_b(), pack_m(1'b1)); else n_pass++;
            // Requesters follow the protocol as seen by the full-budget instance
            for (int i = 0; i < 3; i++) begin
                if (m_gnt[0][2'(i)]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        req[2'(i)] = 1'b0;
                    end else begin
                        a_tbl[2'(i)] = 11'($urandom); d_tbl[2'(i)] = 2'($urandom);
                    end
                end else if (!req[2'(i)] && $urandom_range(0, 3) == 0) begin
                    req[2'(i)] = 1'b1;
                    a_tbl[2'(i)] = 11'($urandom); d_tbl[2'(i)] = 2'($urandom);
                end
            end
            drive_bus();
        end
        reset = 0;
        clear_missed = 0;
    endtask

    initial begin
        m_max[0] = 256;
        m_max[1] = 4;
        reset = 1; ycount = 0; req = 0; req_addr = 0; req_data = 0; clear_missed = 0;
        for (int i = 0; i < 3; i++) begin
            a_tbl[i] = 0; d_tbl[i] = 0;
        end
        model_reset(1'b0);
        model_reset(1'b1);
        @(negedge clk);
        test_reset();
        test_sweep();
        test_rotation();
        test_single();
        test_budget();
        test_display_req();
        test_missed_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
